// File: rtl/conv_feeder.sv
// conv_feeder: streaming front end for the 3x3 convolver. Loads nine serial
// weights into the convolver with one w_w strike, then turns a row-major
// pixel stream into 3x3 windows (two line buffers + 3x3 register window)
// and presents each complete window with a one-cycle if_w strike.
//
// Ports:
//   clk, rst (sync, active-low)
//   start, load_w           frame request (sampled in IDLE only)
//   wt_valid/wt_data/wt_ready     weight stream in
//   pix_valid/pix_data/pix_ready  pixel stream in
//   w_w, w_out0..w_out8     weight strike + held weights
//   if_w, if_out0..if_out8  window strike + held window (8 = newest pixel)
//   frame_done, busy        status
//
// Build option: define FEEDER_STRIDE2_EN to emit only windows whose
// anchor (r-2, c-2) is even in both dimensions (stride 2).

module conv_feeder #(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              load_w,
    input  logic              wt_valid,
    input  logic [DATA_W-1:0] wt_data,
    output logic              wt_ready,
    input  logic              pix_valid,
    input  logic [DATA_W-1:0] pix_data,
    output logic              pix_ready,
    output logic              w_w,
    output logic [DATA_W-1:0] w_out0,
    output logic [DATA_W-1:0] w_out1,
    output logic [DATA_W-1:0] w_out2,
    output logic [DATA_W-1:0] w_out3,
    output logic [DATA_W-1:0] w_out4,
    output logic [DATA_W-1:0] w_out5,
    output logic [DATA_W-1:0] w_out6,
    output logic [DATA_W-1:0] w_out7,
    output logic [DATA_W-1:0] w_out8,
    output logic              if_w,
    output logic [DATA_W-1:0] if_out0,
    output logic [DATA_W-1:0] if_out1,
    output logic [DATA_W-1:0] if_out2,
    output logic [DATA_W-1:0] if_out3,
    output logic [DATA_W-1:0] if_out4,
    output logic [DATA_W-1:0] if_out5,
    output logic [DATA_W-1:0] if_out6,
    output logic [DATA_W-1:0] if_out7,
    output logic [DATA_W-1:0] if_out8,
    output logic              frame_done,
    output logic              busy
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_WSTRB,
        S_STREAM,
        S_DONE
    } state_e;

    state_e            state_q;
    logic [3:0]        wcnt_q;
    logic [CW-1:0]     c_q;
    logic [RW-1:0]     r_q;

    logic [DATA_W-1:0] wstage_q [9];
    logic [DATA_W-1:0] wout_q   [9];
    logic [DATA_W-1:0] win_q    [9];
    logic [DATA_W-1:0] ifout_q  [9];
    logic [DATA_W-1:0] win_d    [9];

    // lb1 holds row r-1, lb2 holds row r-2, both indexed by column
    logic [DATA_W-1:0] lb1_q [IMG_W];
    logic [DATA_W-1:0] lb2_q [IMG_W];

    logic wt_ready_q;
    logic pix_ready_q;
    logic w_w_q;
    logic if_w_q;
    logic frame_done_q;
    logic busy_q;

    logic              wt_acc;
    logic              pix_acc;
    logic              last_pix;
    logic              emit;
    logic [DATA_W-1:0] top_px;
    logic [DATA_W-1:0] mid_px;

    // ready flops are only ever set in their own state
    assign wt_acc   = wt_valid & wt_ready_q;
    assign pix_acc  = pix_valid & pix_ready_q;
    assign last_pix = (r_q == R_LAST) && (c_q == C_LAST);

    assign top_px = lb2_q[c_q];
    assign mid_px = lb1_q[c_q];

    // Window after shifting in the current column of rows r-2, r-1, r
    always_comb begin
        for (int dr = 0; dr < 3; dr++) begin
            win_d[3*dr]     = win_q[3*dr+1];
            win_d[3*dr + 1] = win_q[3*dr+2];
            win_d[3*dr + 2] = win_q[3*dr+2];
        end
        win_d[2] = top_px;
        win_d[5] = mid_px;
        win_d[8] = pix_data;
    end

    // Rows/columns 0 and 1 only fill the window; they never complete one
    always_comb begin
        emit = (r_q >= RW'(2)) && (c_q >= CW'(2));
`ifdef FEEDER_STRIDE2_EN
        emit = emit && !r_q[0] && !c_q[0];
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            wcnt_q       <= '0;
            c_q          <= '0;
            r_q          <= '0;
            wt_ready_q   <= 1'b0;
            pix_ready_q  <= 1'b0;
            w_w_q        <= 1'b0;
            if_w_q       <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                wstage_q[i] <= '0;
                wout_q[i]   <= '0;
                win_q[i]    <= '0;
                ifout_q[i]  <= '0;
            end
        end else begin
            w_w_q        <= 1'b0;
            if_w_q       <= 1'b0;
            frame_done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        if (load_w) begin
                            state_q    <= S_LOAD_W;
                            wt_ready_q <= 1'b1;
                        end else begin
                            state_q     <= S_STREAM;
                            pix_ready_q <= 1'b1;
                        end
                    end
                end
                S_LOAD_W: begin
                    if (wt_acc) begin
                        for (int i = 0; i < 8; i++) begin
                            wstage_q[i] <= wstage_q[i+1];
                        end
                        wstage_q[8] <= wt_data;
                        if (wcnt_q == 4'd8) begin
                            // publish the full set so it is visible in WSTRB
                            for (int i = 0; i < 8; i++) begin
                                wout_q[i] <= wstage_q[i+1];
                            end
                            wout_q[8]  <= wt_data;
                            wcnt_q     <= '0;
                            wt_ready_q <= 1'b0;
                            w_w_q      <= 1'b1;
                            state_q    <= S_WSTRB;
                        end else begin
                            wcnt_q <= wcnt_q + 4'd1;
                        end
                    end
                end
                S_WSTRB: begin
                    state_q     <= S_STREAM;
                    pix_ready_q <= 1'b1;
                end
                S_STREAM: begin
                    if (pix_acc) begin
                        win_q <= win_d;
                        if (emit) begin
                            if_w_q  <= 1'b1;
                            ifout_q <= win_d;
                        end
                        if (c_q == C_LAST) begin
                            c_q <= '0;
                            r_q <= (r_q == R_LAST) ? '0 : r_q + RW'(1);
                        end else begin
                            c_q <= c_q + CW'(1);
                        end
                        if (last_pix) begin
                            pix_ready_q  <= 1'b0;
                            frame_done_q <= 1'b1;
                            state_q      <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Line buffers are deliberately not cleared; the r>=2 qualification
    // keeps stale rows from a previous frame out of emitted windows.
    always_ff @(posedge clk) begin
        if (rst && pix_acc) begin
            lb2_q[c_q] <= lb1_q[c_q];
            lb1_q[c_q] <= pix_data;
        end
    end

    assign wt_ready   = wt_ready_q;
    assign pix_ready  = pix_ready_q;
    assign w_w        = w_w_q;
    assign if_w       = if_w_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

    assign w_out0 = wout_q[0];
    assign w_out1 = wout_q[1];
    assign w_out2 = wout_q[2];
    assign w_out3 = wout_q[3];
    assign w_out4 = wout_q[4];
    assign w_out5 = wout_q[5];
    assign w_out6 = wout_q[6];
    assign w_out7 = wout_q[7];
    assign w_out8 = wout_q[8];

    assign if_out0 = ifout_q[0];
    assign if_out1 = ifout_q[1];
    assign if_out2 = ifout_q[2];
    assign if_out3 = ifout_q[3];
    assign if_out4 = ifout_q[4];
    assign if_out5 = ifout_q[5];
    assign if_out6 = ifout_q[6];
    assign if_out7 = ifout_q[7];
    assign if_out8 = ifout_q[8];

endmodule

// File: tb/tb_conv_feeder.sv
// tb_conv_feeder: directed bench for conv_feeder with a frame-level window
// model (expected windows cut straight out of the image array).

module tb_conv_feeder;

    localparam int W = 8;
    localparam int H = 8;
    localparam int D = 8;
`ifdef FEEDER_STRIDE2_EN
    localparam bit STRIDE2 = 1'b1;
`else
    localparam bit STRIDE2 = 1'b0;
`endif
    localparam int NWIN = STRIDE2 ? ((H - 1) / 2) * ((W - 1) / 2)
                                  : (H - 2) * (W - 2);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, start, load_w;
    logic         wt_valid, wt_ready, pix_valid, pix_ready;
    logic [D-1:0] wt_data, pix_data;
    logic         w_w, if_w, frame_done, busy;
    logic [D-1:0] w_out0, w_out1, w_out2, w_out3, w_out4;
    logic [D-1:0] w_out5, w_out6, w_out7, w_out8;
    logic [D-1:0] if_out0, if_out1, if_out2, if_out3, if_out4;
    logic [D-1:0] if_out5, if_out6, if_out7, if_out8;

    conv_feeder #(.IMG_W(W), .IMG_H(H), .DATA_W(D)) dut (
        .clk(clk), .rst(rst), .start(start), .load_w(load_w),
        .wt_valid(wt_valid), .wt_data(wt_data), .wt_ready(wt_ready),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
        .w_w(w_w),
        .w_out0(w_out0), .w_out1(w_out1), .w_out2(w_out2),
        .w_out3(w_out3), .w_out4(w_out4), .w_out5(w_out5),
        .w_out6(w_out6), .w_out7(w_out7), .w_out8(w_out8),
        .if_w(if_w),
        .if_out0(if_out0), .if_out1(if_out1), .if_out2(if_out2),
        .if_out3(if_out3), .if_out4(if_out4), .if_out5(if_out5),
        .if_out6(if_out6), .if_out7(if_out7), .if_out8(if_out8),
        .frame_done(frame_done), .busy(busy)
    );

    wire [9*D-1:0] got_win = {if_out8, if_out7, if_out6, if_out5, if_out4,
                              if_out3, if_out2, if_out1, if_out0};
    wire [9*D-1:0] got_wts = {w_out8, w_out7, w_out6, w_out5, w_out4,
                              w_out3, w_out2, w_out1, w_out0};

    int passed = 0;
    int total  = 0;
    int strobes = 0;
    int fdones  = 0;
    int wpulses = 0;
    logic acc_prev = 1'b0;

    logic [D-1:0]   img [H][W];
    logic [9*D-1:0] exp_q [$];

    task automatic chk(input string nm, input logic [127:0] got,
                       input logic [127:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: fill the frame, then list every window the rules allow
    function automatic void build_frame(input int k, input int off);
        logic [9*D-1:0] w;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = D'((r * W + c) * k + off);
        exp_q.delete();
        for (int r = 2; r < H; r++) begin
            for (int c = 2; c < W; c++) begin
                if (STRIDE2 && (((r - 2) % 2) != 0 || ((c - 2) % 2) != 0))
                    continue;
                for (int dr = 0; dr < 3; dr++)
                    for (int dc = 0; dc < 3; dc++)
                        w[(3*dr+dc)*D +: D] = img[r-2+dr][c-2+dc];
                exp_q.push_back(w);
            end
        end
    endfunction

    function automatic logic [9*D-1:0] pack9(input int a0, input int step);
        logic [9*D-1:0] v;
        for (int i = 0; i < 9; i++)
            v[i*D +: D] = D'(a0 + (i / 3) * W * step + (i % 3) * step);
        return v;
    endfunction

    always @(posedge clk) acc_prev <= pix_valid && pix_ready;

    always @(negedge clk) begin
        if (if_w === 1'b1) begin
            strobes++;
            chk("if_w_without_accept", acc_prev, 1'b1);
            if (exp_q.size() != 0) begin
                chk("window", got_win, exp_q.pop_front());
            end else begin
                total++;
                $display("FAIL extra_window: got %h expected none", got_win);
            end
        end
        if (frame_done === 1'b1) begin
            fdones++;
            chk("done_all_windows_out", exp_q.size(), 0);
`ifndef FEEDER_STRIDE2_EN
            chk("done_with_last_if_w", if_w, 1'b1);
`endif
        end
        if (w_w === 1'b1) wpulses++;
    end

    task automatic do_start(input bit lw);
        start  = 1'b1;
        load_w = lw;
        tick();
        start  = 1'b0;
        load_w = 1'b0;
    endtask

    task automatic send_wt(input logic [D-1:0] v);
        int n = 0;
        wt_valid = 1'b1;
        wt_data  = v;
        while (!wt_ready && n < 50) begin
            tick();
            n++;
        end
        if (!wt_ready) chk("wt_ready_timeout", wt_ready, 1'b1);
        tick();
        wt_valid = 1'b0;
    endtask

    task automatic send_pix(input logic [D-1:0] v);
        int n = 0;
        pix_valid = 1'b1;
        pix_data  = v;
        while (!pix_ready && n < 50) begin
            tick();
            n++;
        end
        if (!pix_ready) chk("pix_ready_timeout", pix_ready, 1'b1);
        tick();
        pix_valid = 1'b0;
    endtask

    task automatic load_weights();
        logic [9*D-1:0] e;
        for (int i = 0; i < 9; i++) e[i*D +: D] = D'(i + 1);
        chk("wt_ready_in_load", wt_ready, 1'b1);
        for (int i = 0; i < 9; i++) send_wt(D'(i + 1));
        chk("w_w_strike", w_w, 1'b1);
        chk("wt_ready_drop", wt_ready, 1'b0);
        chk("w_out_values", got_wts, e);
        chk("pix_ready_not_yet", pix_ready, 1'b0);
        tick();
        chk("w_w_one_cycle", w_w, 1'b0);
        chk("pix_ready_t2", pix_ready, 1'b1);
    endtask

    // cut >= 0: assert reset after that many pixels
    task automatic run_frame(input int k, input int off, input bit bub,
                             input bit lit, input int cut);
        int s0 = strobes;
        int f0 = fdones;
        build_frame(k, off);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r * W + c == cut) begin
                    rst = 1'b0;
                    tick();
                    chk("cut_busy", busy, 1'b0);
                    chk("cut_pix_ready", pix_ready, 1'b0);
                    chk("cut_if_w", if_w, 1'b0);
                    chk("cut_done", frame_done, 1'b0);
                    chk("cut_if_out", got_win, '0);
                    chk("cut_w_out", got_wts, '0);
                    rst = 1'b1;
                    exp_q.delete();
                    repeat (3) tick();
                    chk("cut_no_frame_done", fdones - f0, 0);
                    return;
                end
                if (bub) begin
                    pix_valid = 1'b0;
                    tick();
                end
                send_pix(img[r][c]);
                if (lit && r == 2 && c == 2) begin
                    chk("first_if_w", if_w, 1'b1);
                    chk("first_window", got_win,
                        {8'd18, 8'd17, 8'd16, 8'd10, 8'd9, 8'd8,
                         8'd2, 8'd1, 8'd0});
                end
`ifdef FEEDER_STRIDE2_EN
                if (lit && r == 2 && c == 3)
                    chk("stride_skip_if_w", if_w, 1'b0);
                if (lit && r == 2 && c == 4)
                    chk("second_window", got_win, pack9(2, 1));
`else
                if (lit && r == 2 && c == 3)
                    chk("second_window", got_win, pack9(1, 1));
`endif
            end
        end
        chk("frame_done_t1", frame_done, 1'b1);
        tick();
        chk("frame_done_pulse", frame_done, 1'b0);
        chk("busy_fall", busy, 1'b0);
        chk("window_count", strobes - s0, NWIN);
        chk("done_count", fdones - f0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; start = 1'b0; load_w = 1'b0;
        wt_valid = 1'b0; wt_data = '0;
        pix_valid = 1'b0; pix_data = '0;
        repeat (3) tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_wt_ready", wt_ready, 1'b0);
        chk("rst_pix_ready", pix_ready, 1'b0);
        chk("rst_w_w", w_w, 1'b0);
        chk("rst_if_w", if_w, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_w_out", got_wts, '0);
        chk("rst_if_out", got_win, '0);
        rst = 1'b1;
        tick();

        // weights 1..9 then an 8r+c frame with no bubbles
        do_start(1'b1);
        load_weights();
        chk("w_w_pulses_1", wpulses, 1);
        run_frame(1, 0, 1'b0, 1'b1, -1);

        // same frame with a bubble before every pixel, reused weights
        tick();
        do_start(1'b0);
        chk("no_load_pix_ready", pix_ready, 1'b1);
        chk("no_load_wt_ready", wt_ready, 1'b0);
        run_frame(1, 0, 1'b1, 1'b1, -1);

        // different data over stale line buffers
        do_start(1'b0);
        run_frame(3, 5, 1'b0, 1'b0, -1);
        chk("w_w_pulses_reuse", wpulses, 1);
        chk("w_out_held", got_wts, pack9(1, 1) & '0 |
            {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1});

        // reset after 20 pixels, then a fresh frame
        do_start(1'b0);
        run_frame(1, 0, 1'b0, 1'b0, 20);
        do_start(1'b1);
        load_weights();
        run_frame(1, 0, 1'b0, 1'b1, -1);
        chk("w_w_pulses_end", wpulses, 2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/conv_feeder.md
# conv_feeder

Streaming front end for the 3x3 convolution datapath. It accepts one serial weight stream and one serial row-major pixel stream, each with a valid/ready handshake. It loads the nine weights into the convolver with a single `w_w` strike. It then builds 3x3 windows with two line buffers and presents each complete window to the convolver with a one-cycle `if_w` strike. It sits directly upstream of the CONV/PRelu pair and drives their `w_w`/`w_in*` and `if_w`/`if_in*` ports.

## Interface
- `IMG_W`, default 8: pixels per row; legal range 3..256.
- `IMG_H`, default 8: rows per frame; legal range 3..256.
- `DATA_W`, default 8: pixel/weight width, signed two's complement.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a frame; sampled only in IDLE.
- `load_w`  in  1  sampled with `start`; 1 = load 9 new weights first, 0 = reuse the held weights.
- `wt_valid`  in  1  weight beat valid.
- `wt_data`  in  DATA_W  weight beat.
- `wt_ready`  out  1  high only in LOAD_W.
- `pix_valid`  in  1  pixel beat valid.
- `pix_data`  in  DATA_W  pixel beat, row-major.
- `pix_ready`  out  1  high only in STREAM.
- `w_w`  out  1  one-cycle weight write strobe to the convolver.
- `w_out0`..`w_out8`  out  DATA_W each  weights in arrival order.
- `if_w`  out  1  one-cycle window write strobe.
- `if_out0`..`if_out8`  out  DATA_W each  window; index = 3*dr + dc, dr/dc = 0 is oldest row / leftmost column; `if_out8` = newest pixel.
- `frame_done`  out  1  one-cycle pulse after the last window of a frame.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- A beat transfers on a cycle where valid and ready are both high. No backpressure exists toward the convolver.
- States and transitions:
  - IDLE: on `start`=1, go to LOAD_W if `load_w`=1, else to STREAM.
  - LOAD_W: accept beats, with the weight counter running 0..8. The 9th beat moves to WSTRB.
  - WSTRB: hold for exactly one cycle with `w_w`=1 and `w_out0..8` updated, then go to STREAM.
  - STREAM: accept IMG_W*IMG_H pixels, tracking column `c` and row `r`. The last beat moves to DONE.
  - DONE: hold for one cycle with `frame_done`=1, then go to IDLE.
- Weights are shifted into a 9-entry staging register. `w_out*` changes only in WSTRB and holds across frames.
- Line buffers:
  - Two IMG_W-deep buffers hold rows r-1 and r-2.
  - A 3x3 register window shifts left on every accepted pixel.
  - The line buffers are written with the new pixel and with the row-(r-1) readout.
- A window is complete when the accepted pixel has `r`>=2 and `c`>=2. There are (IMG_H-2)*(IMG_W-2) windows per frame. Windows never wrap across row boundaries.
- `if_out*` holds the last emitted window between strobes.
- `start` outside IDLE is ignored. A `wt_valid` or `pix_valid` beat outside its state is not accepted.
- Line-buffer contents are not cleared between frames. Correctness relies on the `r`>=2 qualification.

## Timing
- Reset values:
  - state = IDLE.
  - All counters = 0.
  - `w_w`, `if_w`, `frame_done`, `busy`, `wt_ready`, `pix_ready` = 0.
  - `w_out*`, `if_out*` = 0.
- Weight latency: the 9th weight is accepted at cycle t. `w_w`=1 at t+1. `pix_ready` first goes high at t+2.
- Window latency: a completing pixel accepted at cycle t produces `if_w`=1 with its window at t+1. Back-to-back pixels give back-to-back strobes.
- Frame end: the last pixel is accepted at t. The last `if_w` and `frame_done` both occur at t+1. `busy` falls at t+2. The earliest next `start` is accepted at t+2.
- Bubbles (`pix_valid`=0) stall the counters and window. `if_w` stays 0 during a bubble.
- Reset asserted mid-frame returns the block to reset values on the next edge. The partial frame is discarded and no `frame_done` is produced.

## Configuration
- `FEEDER_STRIDE2_EN` defined: a window is emitted only when (`r`-2) and (`c`-2) are both even.
  - This gives ceil((IMG_H-2)/2)*ceil((IMG_W-2)/2) windows per frame.
  - `frame_done` timing is unchanged.
- Not defined: stride 1, every complete window is emitted.

## Test plan
- Reset, then `start` with `load_w`=1 and weights 1..9 back-to-back -> `w_w` high for exactly one cycle with `w_out0`=1 ... `w_out8`=9. `wt_ready` drops the same cycle.
- 8x8 frame, pixel value = 8r+c, no bubbles:
  - Exactly 36 `if_w` pulses.
  - First window `if_out0..8` = 0,1,2,8,9,10,16,17,18, one cycle after pixel 18.
  - `frame_done` on the same cycle as the 36th strobe.
- Same frame with `pix_valid` toggled every other cycle -> identical window sequence and count. `if_w` never asserts in bubble-following cycles without an accepted pixel.
- Second frame with `load_w`=0 -> no `w_w`, `w_out*` still 1..9, windows correct despite stale line buffers.
- `rst` low after 20 pixels -> all outputs 0 next cycle, no `frame_done`. A fresh frame afterward yields 36 correct windows.
- With `FEEDER_STRIDE2_EN`, 8x8 frame -> 9 windows. The first window is anchored at (2,2) and the second at (2,4) (newest pixel 20).
